// File: rtl/fan_pkg.sv
// Shared definitions for the fan duty scheduler: fan level encodings,
// level-to-duty constants and the ramp FSM state enumeration.
package fan_pkg;

  typedef enum logic [1:0] {
    LVL_OFF = 2'd0,
    LVL_1   = 2'd1,
    LVL_2   = 2'd2,
    LVL_3   = 2'd3
  } level_e;

  localparam logic [6:0] DUTY_L0 = 7'd0;
  localparam logic [6:0] DUTY_L1 = 7'd33;
  localparam logic [6:0] DUTY_L2 = 7'd66;
  localparam logic [6:0] DUTY_L3 = 7'd99;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

  function automatic logic [6:0] level_to_duty(input logic [1:0] lvl);
    case (lvl)
      LVL_1:   level_to_duty = DUTY_L1;
      LVL_2:   level_to_duty = DUTY_L2;
      LVL_3:   level_to_duty = DUTY_L3;
      default: level_to_duty = DUTY_L0;
    endcase
  endfunction

endpackage

// File: rtl/fan_ramp_tick.sv
// Ramp step prescaler: pulses strobe once every RAMP_DIV clk cycles.
// Ports:
//   clk     - clock
//   reset_n - synchronous active-low reset
//   clear   - restart the count from zero (held while not ramping)
//   strobe  - one-cycle step pulse, high in the last cycle of each period
module fan_ramp_tick
  #(parameter int RAMP_DIV = 100000)
  (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic strobe
  );

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign strobe = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || strobe) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fan_duty_sched.sv
// Fan duty scheduler: selects a fan level (manual button or temperature
// driven auto mode), gates it off on timer expiry or absence of a person,
// and ramps the PWM duty toward the level's target one step at a time.
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   speed_btn_pe          - pulse: advance manual level (leaves auto mode)
//   auto_btn_pe           - pulse: toggle auto mode
//   timer_stop            - level: off-timer expired, stop the fan
//   distance_cm           - ultrasonic distance; far away stops the fan
//   temperature           - degrees C, drives the auto level
//   duty                  - PWM duty 0..99
//   level                 - effective level 0..3
//   auto_on               - auto mode active
//   fan_run               - duty is nonzero
module fan_duty_sched
  import fan_pkg::*;
  #(
    parameter int RAMP_DIV = 100000,
    parameter int NEAR_CM  = 20,
    parameter int T_LO     = 25,
    parameter int T_HI     = 30
  )
  (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        speed_btn_pe,
    input  logic        auto_btn_pe,
    input  logic        timer_stop,
    input  logic [15:0] distance_cm,
    input  logic [7:0]  temperature,
    output logic [6:0]  duty,
    output logic [1:0]  level,
    output logic        auto_on,
    output logic        fan_run
  );

  state_e      state_q, state_d;
  logic [6:0]  duty_q, duty_d;
  logic [1:0]  level_q, level_d;
  logic        auto_on_q, auto_on_d;
  logic        gate_q, gate_d;

  logic        gate;
  logic        gate_rise;
  logic [1:0]  auto_lvl;
  logic [6:0]  target;
  logic        strobe;
  logic        tick_clear;

  assign gate      = timer_stop || (distance_cm >= 16'(NEAR_CM));
  assign gate_d    = gate;
  assign gate_rise = gate && !gate_q;
  assign target    = gate ? DUTY_L0 : level_to_duty(level_q);

  always_comb begin
    if (temperature < 8'(T_LO))      auto_lvl = LVL_1;
    else if (temperature < 8'(T_HI)) auto_lvl = LVL_2;
    else                             auto_lvl = LVL_3;
  end

  // Level/mode selection. Frozen while gated so the fan resumes at the
  // same target. In auto mode level_q holds the current auto level, so a
  // speed press moves to auto level + 1 through the same increment path.
  always_comb begin
    auto_on_d = auto_on_q;
    level_d   = level_q;
    if (!gate) begin
      if (auto_btn_pe) begin
        auto_on_d = !auto_on_q;
      end else if (speed_btn_pe) begin
        auto_on_d = 1'b0;
        level_d   = level_q + 2'd1;
      end
      if (auto_on_d) level_d = auto_lvl;
    end
  end

  // Ramp FSM. A step never overshoots: the transition to HOLD/IDLE is
  // taken on the same edge that lands duty on the target.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (gate_rise) begin
      state_d = IDLE;
      duty_d  = 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          duty_d = 7'd0;
          if (target > 7'd0) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (target < duty_q) begin
            state_d = RAMP_DOWN;
          end else if (target == duty_q) begin
            state_d = (duty_q == 7'd0) ? IDLE : HOLD;
          end else if (strobe) begin
            duty_d = duty_q + 7'd1;
            if (duty_d == target) state_d = HOLD;
          end
        end
        HOLD: begin
          if (target > duty_q)      state_d = RAMP_UP;
          else if (target < duty_q) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (target > duty_q) begin
            state_d = RAMP_UP;
          end else if (target == duty_q) begin
            state_d = (duty_q == 7'd0) ? IDLE : HOLD;
          end else if (strobe) begin
            duty_d = duty_q - 7'd1;
            if (duty_d == 7'd0)        state_d = IDLE;
            else if (duty_d == target) state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = 7'd0;
        end
      endcase
    end
  end

  // Prescaler runs only inside a ramp state and restarts on every state
  // change, so the first step lands a full period after entering a ramp.
  assign tick_clear = (state_d != state_q) ||
                      !((state_q == RAMP_UP) || (state_q == RAMP_DOWN));

  fan_ramp_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tick_clear),
    .strobe  (strobe)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      duty_q    <= 7'd0;
      level_q   <= 2'd0;
      auto_on_q <= 1'b0;
      gate_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      level_q   <= level_d;
      auto_on_q <= auto_on_d;
      gate_q    <= gate_d;
    end
  end

  assign duty    = duty_q;
  assign level   = level_q;
  assign auto_on = auto_on_q;
  assign fan_run = (duty_q != 7'd0);

endmodule

// File: tb/tb_fan_duty_sched.sv
// Directed bench for fan_duty_sched with RAMP_DIV = 4. Stimulus pushes
// hand-computed expectations tagged with the cycle they apply to; a
// monitor on the falling edge pops and compares them.
module tb_fan_duty_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        speed_btn_pe;
  logic        auto_btn_pe;
  logic        timer_stop;
  logic [15:0] distance_cm;
  logic [7:0]  temperature;
  logic [6:0]  duty;
  logic [1:0]  level;
  logic        auto_on;
  logic        fan_run;

  fan_duty_sched #(
    .RAMP_DIV (4),
    .NEAR_CM  (20),
    .T_LO     (25),
    .T_HI     (30)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .speed_btn_pe (speed_btn_pe),
    .auto_btn_pe  (auto_btn_pe),
    .timer_stop   (timer_stop),
    .distance_cm  (distance_cm),
    .temperature  (temperature),
    .duty         (duty),
    .level        (level),
    .auto_on      (auto_on),
    .fan_run      (fan_run)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] duty;
    logic [1:0] lvl;
    logic       aut;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic push_exp(input int c, input string nm, input logic [6:0] d,
                          input logic [1:0] l, input logic a);
    exp_t e;
    e.cyc = c; e.name = nm; e.duty = d; e.lvl = l; e.aut = a;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic exp_run;
      e = sb.pop_front();
      exp_run = (e.duty != 7'd0);
      checks++;
      if (e.cyc != cyc || duty !== e.duty || level !== e.lvl ||
          auto_on !== e.aut || fan_run !== exp_run) begin
        errors++;
        $display("FAIL %s @cyc %0d (due %0d): got duty=%0d level=%0d auto_on=%0d fan_run=%0d, want duty=%0d level=%0d auto_on=%0d fan_run=%0d",
                 e.name, cyc, e.cyc, duty, level, auto_on, fan_run,
                 e.duty, e.lvl, e.aut, exp_run);
      end
    end
  end

  initial begin
    int t;
    reset_n      = 1'b0;
    speed_btn_pe = 1'b0;
    auto_btn_pe  = 1'b0;
    timer_stop   = 1'b0;
    distance_cm  = 16'd10;
    temperature  = 8'd20;
    goto(3);
    push_exp(3, "reset", 0, 0, 0);
    reset_n = 1'b1;

    // Manual level 1: ramp 0 -> 33, one step per 4 cycles
    t = cyc;
    push_exp(t+1,   "a_lvl1",   0,  1, 0);
    push_exp(t+5,   "a_pre",    0,  1, 0);
    push_exp(t+6,   "a_d1",     1,  1, 0);
    push_exp(t+10,  "a_d2",     2,  1, 0);
    push_exp(t+133, "a_d32",    32, 1, 0);
    push_exp(t+134, "a_hold33", 33, 1, 0);
    push_exp(t+200, "a_hold",   33, 1, 0);
    speed_btn_pe = 1'b1; goto(t+1); speed_btn_pe = 1'b0;
    goto(t+200);

    // Level 2, person leaves at duty 50, returns
    t = cyc;
    push_exp(t+1,   "b_lvl2",  33, 2, 0);
    push_exp(t+6,   "b_d34",   34, 2, 0);
    push_exp(t+70,  "b_d50",   50, 2, 0);
    push_exp(t+71,  "b_gate",  0,  2, 0);
    push_exp(t+80,  "b_gated", 0,  2, 0);
    push_exp(t+85,  "b_r1",    1,  2, 0);
    push_exp(t+344, "b_d65",   65, 2, 0);
    push_exp(t+345, "b_d66",   66, 2, 0);
    push_exp(t+360, "b_hold",  66, 2, 0);
    speed_btn_pe = 1'b1; goto(t+1); speed_btn_pe = 1'b0;
    goto(t+70);  distance_cm = 16'd25;
    goto(t+80);  distance_cm = 16'd10;
    goto(t+360);

    // Level 3 to 99, then wrap to 0 and ramp down to IDLE
    t = cyc;
    push_exp(t+1,   "c_lvl3",  66, 3, 0);
    push_exp(t+134, "c_d99",   99, 3, 0);
    push_exp(t+141, "c_lvl0",  99, 0, 0);
    push_exp(t+146, "c_d98",   98, 0, 0);
    push_exp(t+342, "c_d49",   49, 0, 0);
    push_exp(t+537, "c_d1",    1,  0, 0);
    push_exp(t+538, "c_idle",  0,  0, 0);
    push_exp(t+550, "c_off",   0,  0, 0);
    speed_btn_pe = 1'b1; goto(t+1); speed_btn_pe = 1'b0;
    goto(t+140);
    speed_btn_pe = 1'b1; goto(t+141); speed_btn_pe = 1'b0;
    goto(t+550);

    // Auto mode across temperature bands, simultaneous buttons,
    // speed press while in auto at level 3 wraps to 0
    t = cyc;
    push_exp(t+1,  "d_auto24",   0, 1, 1);
    push_exp(t+6,  "d_d1",       1, 1, 1);
    push_exp(t+11, "d_t27",      2, 2, 1);
    push_exp(t+13, "d_t31",      2, 3, 1);
    push_exp(t+21, "d_both",     4, 3, 0);
    push_exp(t+22, "d_d5",       5, 3, 0);
    push_exp(t+31, "d_auto_on",  7, 3, 1);
    push_exp(t+41, "d_spd_auto", 9, 0, 0);
    push_exp(t+42, "d_down",     9, 0, 0);
    push_exp(t+46, "d_d8",       8, 0, 0);
    push_exp(t+78, "d_idle",     0, 0, 0);
    push_exp(t+85, "d_off",      0, 0, 0);
    temperature = 8'd24;
    auto_btn_pe = 1'b1; goto(t+1); auto_btn_pe = 1'b0;
    goto(t+10); temperature = 8'd27;
    goto(t+12); temperature = 8'd31;
    goto(t+20); auto_btn_pe = 1'b1; speed_btn_pe = 1'b1;
    goto(t+21); auto_btn_pe = 1'b0; speed_btn_pe = 1'b0;
    goto(t+30); auto_btn_pe = 1'b1;
    goto(t+31); auto_btn_pe = 1'b0;
    goto(t+40); speed_btn_pe = 1'b1;
    goto(t+41); speed_btn_pe = 1'b0;
    goto(t+85);

    // Off-timer at duty 66 keeps level and resumes
    t = cyc;
    push_exp(t+1,   "e_lvl1",    0,  1, 0);
    push_exp(t+3,   "e_lvl2",    0,  2, 0);
    push_exp(t+6,   "e_d1",      1,  2, 0);
    push_exp(t+266, "e_d66",     66, 2, 0);
    push_exp(t+270, "e_hold",    66, 2, 0);
    push_exp(t+271, "e_tstop",   0,  2, 0);
    push_exp(t+275, "e_stopped", 0,  2, 0);
    push_exp(t+280, "e_r1",      1,  2, 0);
    push_exp(t+540, "e_d66b",    66, 2, 0);
    speed_btn_pe = 1'b1; goto(t+1); speed_btn_pe = 1'b0;
    goto(t+2); speed_btn_pe = 1'b1; goto(t+3); speed_btn_pe = 1'b0;
    goto(t+270); timer_stop = 1'b1;
    goto(t+275); timer_stop = 1'b0;
    goto(t+540);

    // Reset mid ramp-up at duty 40
    t = cyc;
    push_exp(t+1,   "f_gate",  0,  2, 0);
    push_exp(t+162, "f_d40",   40, 2, 0);
    push_exp(t+163, "f_d40b",  40, 2, 0);
    push_exp(t+164, "f_reset", 0,  0, 0);
    push_exp(t+170, "f_after", 0,  0, 0);
    distance_cm = 16'd25; goto(t+1); distance_cm = 16'd10;
    goto(t+163); reset_n = 1'b0;
    goto(t+164); reset_n = 1'b1;
    goto(t+172);

    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL pending: %0d expectations never compared, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_duty_sched.md
FAN_DUTY_SCHED -- requirements
Module: fan_duty_sched

Interface
- REQ-001 SHALL have parameter RAMP_DIV, default 100000: clk cycles per duty ramp step (1 ms at 100 MHz).
- REQ-002 SHALL have parameter NEAR_CM, default 20: presence threshold in cm.
- REQ-003 SHALL have parameters T_LO, default 25, and T_HI, default 30: auto-mode temperature thresholds in °C.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock.
- REQ-005 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
- REQ-006 SHALL have port speed_btn_pe, input, 1 bit: one-cycle pulse that advances the manual level.
- REQ-007 SHALL have port auto_btn_pe, input, 1 bit: one-cycle pulse that toggles auto mode.
- REQ-008 SHALL have port timer_stop, input, 1 bit: level signal; 1 = off-timer expired, fan must stop.
- REQ-009 SHALL have port distance_cm, input, 16 bits: ultrasonic distance.
- REQ-010 SHALL have port temperature, input, 8 bits: DHT11 temperature in °C.
- REQ-011 SHALL have port duty, output, 7 bits: PWM duty 0..99, fed to the 100-step PWM.
- REQ-012 SHALL have port level, output, 2 bits: effective level (0 = off, 1..3).
- REQ-013 SHALL have port auto_on, output, 1 bit: auto mode active.
- REQ-014 SHALL have port fan_run, output, 1 bit: 1 whenever duty != 0.

Function
- REQ-015 SHALL map level to target duty: 0→0, 1→33, 2→66, 3→99.
- REQ-016 In manual mode, each speed_btn_pe SHALL advance the level 0→1→2→3→0, registered one cycle after the pulse.
- REQ-017 In auto mode, level SHALL be 1 if temperature < T_LO, 2 if T_LO ≤ temperature < T_HI, and 3 otherwise, re-evaluated every cycle.
- REQ-018 A speed_btn_pe arriving in auto mode SHALL clear auto_on and set the manual level to the current auto level + 1, wrapping 3→0.
- REQ-019 If auto_btn_pe and speed_btn_pe occur in the same cycle, SHALL toggle auto_on and ignore speed_btn_pe.
- REQ-020 gate SHALL equal (timer_stop = 1) OR (distance_cm ≥ NEAR_CM); while gate = 1 the effective target SHALL be 0.
- REQ-021 The FSM SHALL have four states: IDLE, RAMP_UP, HOLD, RAMP_DOWN.
- REQ-022 IDLE: duty = 0; SHALL go to RAMP_UP when target > 0.
- REQ-023 RAMP_UP: duty SHALL increment by 1 per step strobe; SHALL go to HOLD when duty = target, or to RAMP_DOWN when target < duty.
- REQ-024 HOLD: duty SHALL stay constant; SHALL go to RAMP_UP if target > duty, or to RAMP_DOWN if target < duty.
- REQ-025 RAMP_DOWN: duty SHALL decrement by 1 per step strobe; SHALL go to HOLD when duty = target > 0, to IDLE when duty = 0, or to RAMP_UP when target > duty.
- REQ-026 On a rising edge of gate, in any state, SHALL set duty to 0 and the state to IDLE on the next cycle (safety stop, no ramp).
- REQ-027 When gate falls, SHALL ramp up from 0 per REQ-023.
- REQ-028 The step strobe SHALL fire once every RAMP_DIV cycles while in RAMP_UP or RAMP_DOWN.
- REQ-029 The strobe counter SHALL clear on any state change, so the first step occurs RAMP_DIV cycles after entering a ramp state.
- REQ-030 duty SHALL never leave the range 0..99 and SHALL never overshoot target; all comparisons are unsigned 7-bit.
- REQ-031 fan_run SHALL be combinational from duty; all other outputs SHALL be registered.
- REQ-032 level and auto_on SHALL keep their values while gate = 1, so the fan resumes to the same target when gate clears.

Reset
- REQ-033 While reset_n = 0 at a clk edge: state IDLE, duty 0, level 0, auto_on 0, strobe counter 0.
- REQ-034 Reset asserted mid-ramp SHALL take effect on that edge, with no ramp-down.

Structure
- REQ-035 Shared package fan_pkg SHALL hold the level encodings, the level-to-duty constants (0/33/66/99) and the FSM state enumeration.
- REQ-036 The step prescaler SHALL be the sub-module fan_ramp_tick (inputs clk, reset_n, clear; output strobe; parameter RAMP_DIV).
- REQ-037 The implementation SHALL be 120–400 lines of RTL.

Verification (RAMP_DIV = 4, NEAR_CM = 20)
- REQ-038 Bench SHALL cover: distance 10, timer_stop 0, one speed pulse → level 1; duty 1 after 4 cycles, rising by 1 every 4 cycles; HOLD at 33 after 132 cycles.
- REQ-039 Bench SHALL cover: at duty 50 ramping to 66, distance set to 25 → duty 0 and state IDLE on the next cycle; distance back to 10 → ramp from 0 to 66.
- REQ-040 Bench SHALL cover: in HOLD at 99, speed pulse (level 3→0) → RAMP_DOWN, duty −1 every 4 cycles, IDLE at 0.
- REQ-041 Bench SHALL cover: auto pulse with temperature 24/27/31 → level 1/2/3 and target 33/66/99; simultaneous auto and speed pulses → auto toggles and level is unchanged.
- REQ-042 Bench SHALL cover: timer_stop pulsed to 1 at duty 66 → duty 0 next cycle; level is retained; timer_stop to 0 → ramp to 66.
- REQ-043 Bench SHALL cover: reset_n low for one cycle at duty 40 while in RAMP_UP → all outputs 0 and state IDLE on that edge.
